// File: rtl/uart_tx_fifo.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : uart_tx_fifo                                                  |
// | Description : 8N1 UART transmitter fed by a small byte FIFO. Bytes enter    |
// |               over a valid/ready handshake and are serialised LSB first,    |
// |               back-to-back with no idle gap while the FIFO holds data.      |
// | Revision    : 1.0  initial release                                          |
// +-----------------------------------------------------------------------------+
// | Ports                                                                       |
// |   clk    in   rising-edge system clock                                      |
// |   rst_n  in   synchronous reset, active low                                 |
// |   data   in   byte to send, sampled on the push edge only                   |
// |   valid  in   byte offered; accepted on an edge where valid && ready        |
// |   ready  out  FIFO not full (combinational from the fill level)             |
// |   tx     out  serial line, idle high, registered                            |
// |   busy   out  high while a frame is on the line                             |
// |   level  out  bytes held in the FIFO, excluding the byte being sent         |
// +-----------------------------------------------------------------------------+
module uart_tx_fifo #(
   parameter int BAUD       = 115200,
   parameter int CLK_FREQ   = 50000000,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [7:0]                    data,
   input  logic                          valid,
   output logic                          ready,
   output logic                          tx,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   level
);

   localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
   localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int PTR_W        = $clog2(FIFO_DEPTH);
   localparam int LVL_W        = PTR_W + 1;

   localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [LVL_W-1:0] LVL_FULL   = LVL_W'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   // FIFO storage and bookkeeping
   logic [7:0]       mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [LVL_W-1:0] count;
   logic             push;
   logic             pop;

   // Transmit datapath
   state_t           state;
   state_t           state_nx;
   logic [CNT_W-1:0] baud_cnt;
   logic [CNT_W-1:0] baud_cnt_nx;
   logic [2:0]       bit_idx;
   logic [2:0]       bit_idx_nx;
   logic [2:0]       bit_idx_inc;
   logic [7:0]       shift;
   logic [7:0]       shift_nx;
   logic             tx_nx;
   logic             fifo_has_data;

   assign ready         = (count != LVL_FULL);
   assign level         = count;
   assign busy          = (state != IDLE);
   assign push          = valid && ready;
   assign fifo_has_data = (count != '0);
   assign bit_idx_inc   = bit_idx + 3'd1;

   // ------------------------------------------------------------------------
   // FIFO: memory has no reset; only pointers and count define its contents.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         // Power-of-two depth: pointers wrap by natural overflow.
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         // Simultaneous push and pop leaves the level unchanged.
         case ({push, pop})
            2'b10:   count <= count + LVL_W'(1);
            2'b01:   count <= count - LVL_W'(1);
            default: count <= count;
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // FSM state register. tx is registered from its next-state value so the
   // line level changes on the same edge as the state.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         baud_cnt <= '0;
         bit_idx  <= '0;
         shift    <= '0;
         tx       <= 1'b1;
      end else begin
         state    <= state_nx;
         baud_cnt <= baud_cnt_nx;
         bit_idx  <= bit_idx_nx;
         shift    <= shift_nx;
         tx       <= tx_nx;
      end
   end

   // ------------------------------------------------------------------------
   // Next-state and output logic
   // ------------------------------------------------------------------------
   always_comb begin
      state_nx    = state;
      baud_cnt_nx = baud_cnt;
      bit_idx_nx  = bit_idx;
      shift_nx    = shift;
      tx_nx       = 1'b1;
      pop         = 1'b0;

      case (state)
         IDLE: begin
            if (fifo_has_data) begin
               pop         = 1'b1;
               shift_nx    = mem[rd_ptr];
               baud_cnt_nx = CNT_RELOAD;
               state_nx    = START;
               tx_nx       = 1'b0;
            end
         end

         START: begin
            if (baud_cnt == '0) begin
               baud_cnt_nx = CNT_RELOAD;
               bit_idx_nx  = 3'd0;
               state_nx    = DATA;
               tx_nx       = shift[0];
            end else begin
               baud_cnt_nx = baud_cnt - CNT_W'(1);
               tx_nx       = 1'b0;
            end
         end

         DATA: begin
            if (baud_cnt == '0) begin
               baud_cnt_nx = CNT_RELOAD;
               if (bit_idx == 3'd7) begin
                  state_nx = STOP;
                  tx_nx    = 1'b1;
               end else begin
                  bit_idx_nx = bit_idx_inc;
                  tx_nx      = shift[bit_idx_inc];
               end
            end else begin
               baud_cnt_nx = baud_cnt - CNT_W'(1);
               tx_nx       = shift[bit_idx];
            end
         end

         STOP: begin
            if (baud_cnt == '0) begin
               if (fifo_has_data) begin
                  // Chain straight into the next start bit, no idle gap.
                  pop         = 1'b1;
                  shift_nx    = mem[rd_ptr];
                  baud_cnt_nx = CNT_RELOAD;
                  state_nx    = START;
                  tx_nx       = 1'b0;
               end else begin
                  state_nx = IDLE;
               end
            end else begin
               baud_cnt_nx = baud_cnt - CNT_W'(1);
            end
         end

         default: begin
            state_nx = IDLE;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : tb_uart_tx_fifo                                               |
// | Description : Self-checking bench for uart_tx_fifo. Accepted bytes are      |
// |               queued as expected frames; a line receiver decodes tx and     |
// |               compares every frame bit-period against the expected byte.    |
// | Revision    : 1.0  initial release                                          |
// +-----------------------------------------------------------------------------+
module tb_uart_tx_fifo;

   localparam int CLK_FREQ = 1000000;
   localparam int BAUD     = 100000;
   localparam int DEPTH    = 4;
   localparam int CPB      = CLK_FREQ / BAUD;
   localparam int FRAME    = 10 * CPB;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] data  = 8'h00;
   logic       valid = 1'b0;
   logic       ready;
   logic       tx;
   logic       busy;
   logic [2:0] level;

   uart_tx_fifo #(
      .BAUD       (BAUD),
      .CLK_FREQ   (CLK_FREQ),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .data  (data),
      .valid (valid),
      .ready (ready),
      .tx    (tx),
      .busy  (busy),
      .level (level)
   );

   always #5 clk = ~clk;

   int         checks  = 0;
   int         passed  = 0;
   int         cyc     = 0;
   int         acc_cnt = 0;
   int         first_push = 0;
   logic [7:0] exp_q[$];
   logic [7:0] burst[$];
   int         starts[$];
   bit         in_frame = 1'b0;
   int         nsamp = 0;
   logic       samp[FRAME];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Edge counter and scoreboard producer: every accepted byte is an expected frame.
   initial begin
      forever begin
         @(posedge clk);
         if (rst_n && valid && ready) begin
            exp_q.push_back(data);
            acc_cnt++;
         end
         cyc++;
      end
   end

   // Compare one captured frame against the oldest expected byte.
   task automatic check_frame();
      logic [7:0] e;
      logic [7:0] dec;
      logic       eb;
      int         bad;
      bad = 0;
      for (int b = 0; b < 8; b++) dec[b] = samp[CPB * (b + 1) + CPB / 2];
      if (exp_q.size() == 0) begin
         chk("frame_expected", 32'(dec), 32'hFFFF_FFFF);
      end else begin
         e = exp_q.pop_front();
         for (int b = 0; b < 10; b++) begin
            eb = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : e[b - 1];
            for (int s = 0; s < CPB; s++) if (samp[b * CPB + s] !== eb) bad++;
         end
         chk("frame_byte", 32'(dec), 32'(e));
         chk("frame_bit_timing", 32'(bad), 32'd0);
      end
   endtask

   // Line receiver: captures every clock of a frame starting at the falling edge.
   initial begin
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            in_frame = 1'b0;
            exp_q.delete();
         end else if (in_frame || tx == 1'b0) begin
            if (!in_frame) begin
               in_frame = 1'b1;
               nsamp    = 0;
               starts.push_back(cyc);
            end
            samp[nsamp] = tx;
            nsamp++;
            if (nsamp == FRAME) begin
               check_frame();
               in_frame = 1'b0;
            end
         end
      end
   end

   // Offer every byte in burst; optional random idle gaps between offers.
   task automatic send_burst(input int gap_max);
      logic [7:0] b;
      int         n;
      bit         first;
      first = 1'b1;
      while (burst.size() > 0) begin
         b = burst.pop_front();
         if (gap_max > 0) begin
            valid = 1'b0;
            data  = 8'($urandom);
            repeat ($urandom_range(0, gap_max)) tick();
         end
         data  = b;
         valid = 1'b1;
         n     = 0;
         while (!ready && n < 2000) begin
            tick();
            n++;
         end
         if (!ready) begin
            chk("ready_timeout", 32'(ready), 32'd1);
            burst.delete();
         end else begin
            tick();
            if (first) first_push = cyc;
            first = 1'b0;
         end
      end
      valid = 1'b0;
      data  = 8'($urandom);
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((busy || level != 3'd0 || in_frame) && n < 3000) begin
         tick();
         n++;
      end
      chk("drain", 32'(busy || level != 3'd0 || in_frame), 32'd0);
      chk("sb_empty", 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
      $fatal(1);
   end

   initial begin
      int n0;
      int acc0;

      // 1. Reset and idle behaviour
      rst_n = 1'b0;
      repeat (3) tick();
      chk("reset_state", {tx, busy, level, ready}, {1'b1, 1'b0, 3'd0, 1'b1});
      rst_n = 1'b1;
      repeat (50) begin
         tick();
         chk("idle_quiet", {tx, busy, level, ready}, {1'b1, 1'b0, 3'd0, 1'b1});
      end
      chk("idle_no_frame", 32'(starts.size()), 32'd0);

      // 2. Single byte latency and frame
      burst = '{8'hA5};
      send_burst(0);
      n0 = first_push;
      chk("t2_after_push", {tx, busy, level}, {1'b1, 1'b0, 3'd1});
      tick();
      chk("t2_start_edge", {tx, busy, level}, {1'b0, 1'b1, 3'd0});
      while (cyc < n0 + 100) tick();
      chk("t2_busy_end", {tx, busy}, {1'b1, 1'b1});
      tick();
      chk("t2_busy_drop", {tx, busy}, {1'b1, 1'b0});
      wait_idle();
      chk("t2_start_cycle", 32'(starts[starts.size() - 1]), 32'(n0 + 1));

      // 3. Back-to-back burst, FIFO fills
      starts.delete();
      burst = '{8'h00, 8'hFF, 8'h55, 8'h3C, 8'h81};
      send_burst(0);
      n0 = first_push;
      chk("t3_consecutive", 32'(cyc - n0), 32'd4);
      chk("t3_full", {ready, level}, {1'b0, 3'd4});
      while (cyc < n0 + 500) tick();
      chk("t3_busy_end", 32'(busy), 32'd1);
      tick();
      chk("t3_busy_drop", 32'(busy), 32'd0);
      wait_idle();
      chk("t3_frames", 32'(starts.size()), 32'd5);
      for (int i = 0; i < starts.size(); i++)
         chk("t3_contiguous", 32'(starts[i]), 32'(n0 + 1 + FRAME * i));

      // 4. Valid held while full
      starts.delete();
      for (int i = 0; i < 5; i++) burst.push_back(8'($urandom));
      send_burst(0);
      data  = 8'h99;
      valid = 1'b1;
      n0    = 0;
      while (!ready && n0 < 200) begin
         chk("t4_full_hold", {ready, level}, {1'b0, 3'd4});
         tick();
         n0++;
      end
      chk("t4_ready_rose", 32'(ready), 32'd1);
      tick();
      valid = 1'b0;
      data  = 8'h5A;
      chk("t4_level_refill", 32'(level), 32'd4);
      wait_idle();
      chk("t4_frames", 32'(starts.size()), 32'd6);

      // 5. Reset mid DATA bit 3 with two bytes queued
      starts.delete();
      for (int i = 0; i < 3; i++) burst.push_back(8'($urandom));
      send_burst(0);
      n0 = first_push;
      chk("t5_queued", 32'(level), 32'd2);
      while (cyc < n0 + 45) tick();
      rst_n = 1'b0;
      tick();
      chk("t5_abort", {tx, busy, level, ready}, {1'b1, 1'b0, 3'd0, 1'b1});
      rst_n = 1'b1;
      repeat (200) tick();
      chk("t5_no_frames", 32'(starts.size()), 32'd1);
      chk("t5_quiet", {tx, busy, level}, {1'b1, 1'b0, 3'd0});

      // 6. 256 random bytes with random gaps
      acc0 = acc_cnt;
      for (int i = 0; i < 256; i++) burst.push_back(8'($urandom));
      send_burst(3);
      wait_idle();
      chk("t6_accepted", 32'(acc_cnt - acc0), 32'd256);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
`default_nettype wire
